// File: rtl/mul_seq_ctrl.sv
// Sequential signed multiplier controller: shift-add over a shared external add/sub ALU.
// Operand magnitudes are multiplied unsigned, then the sign is applied once at the end.
module mul_seq_ctrl #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_sub,
  output logic           alu_req,
  input  logic [W-1:0]   alu_sum,
  input  logic           alu_c,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod,
  output logic [1:0]     fsm_state
);

  // Handshake: start is accepted only at an edge where busy=0 (IDLE); x/y are
  // captured at that edge. done pulses for one cycle with prod valid, and prod
  // holds until the next accepted start. There is no backpressure or queuing.

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]   m_r;
  logic [W-1:0]   q_r;
  logic [W-1:0]   p_hi;
  logic [CW-1:0]  cnt;
  logic           neg;
  logic [W-1:0]   x_mag;
  logic [W-1:0]   y_mag;
  logic           last_step;
  logic [2*W-1:0] mag_prod;

  // The most negative value maps onto 2^(W-1), which still fits as unsigned.
  assign x_mag     = x[W-1] ? ((~x) + W'(1)) : x;
  assign y_mag     = y[W-1] ? ((~y) + W'(1)) : y;
  assign last_step = (cnt == CW'(W - 1));
  assign mag_prod  = {p_hi, q_r};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_MUL;
      S_MUL:  if (last_step) state_nx = S_SIGN;
      S_SIGN: state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    alu_req   = 1'b0;
    alu_sub   = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    fsm_state = state;
    if (state == S_MUL) begin
      alu_req = 1'b1;
      alu_a   = p_hi;
      alu_b   = q_r[0] ? m_r : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_r  <= '0;
      q_r  <= '0;
      p_hi <= '0;
      cnt  <= '0;
      neg  <= 1'b0;
      prod <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            m_r  <= x_mag;
            q_r  <= y_mag;
            neg  <= x[W-1] ^ y[W-1];
            p_hi <= '0;
            cnt  <= '0;
          end
        end
        S_MUL: begin
          // Carry-out becomes the new top bit; the consumed multiplier bit drops off.
          {p_hi, q_r} <= {alu_c, alu_sum, q_r[W-1:1]};
          cnt         <= cnt + CW'(1);
        end
        S_SIGN: begin
          prod <= neg ? ((~mag_prod) + (2*W)'(1)) : mag_prod;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: table of signed products plus hand-written sequences for
// held start, mid-operation reset and ALU ownership.
module tb_mul_seq_ctrl;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic           alu_sub;
  logic           alu_req;
  logic [W-1:0]   alu_sum;
  logic           alu_c;
  logic           busy;
  logic           done;
  logic [2*W-1:0] prod;
  logic [1:0]     fsm_state;

  int checks   = 0;
  int failures = 0;

  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic signed [W-1:0]   a;
    logic signed [W-1:0]   b;
    logic        [2*W-1:0] p;
  } vec_t;

  vec_t vecs[10];

  mul_seq_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub), .alu_req(alu_req),
    .alu_sum(alu_sum), .alu_c(alu_c), .busy(busy), .done(done),
    .prod(prod), .fsm_state(fsm_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model: unsigned add with carry-out (subtract supported for completeness).
  always_comb begin
    if (alu_sub) {alu_c, alu_sum} = {1'b0, alu_a} + {1'b0, ~alu_b} + (W+1)'(1);
    else         {alu_c, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Outside MUL the controller must leave the ALU interface at zero.
  always @(negedge clk) begin
    if (rst === 1'b1 && alu_req === 1'b0) begin
      check("alu_idle_zero", {alu_sub, alu_a, alu_b}, 32'h0);
    end
    if (alu_req === 1'b1) begin
      check("alu_sub_in_mul", {31'h0, alu_sub}, 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE; start is randomly toggled and x/y scrambled
  // while the operation runs, which must not disturb the result.
  task automatic run_mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                         input logic [2*W-1:0] p);
    int edges;
    int reqs;
    logic [2*W-1:0] e;
    exp_q.push_back(p);
    start = 1'b1;
    x = a;
    y = b;
    step();
    start = 1'b0;
    x = W'($urandom_range(0, 255));
    y = W'($urandom_range(0, 255));
    check("busy_after_accept", {31'h0, busy}, 32'h1);
    edges = 0;
    reqs = 0;
    while (done !== 1'b1 && edges < 30) begin
      if (alu_req === 1'b1) reqs++;
      start = 1'($urandom_range(0, 1));
      x = W'($urandom_range(0, 255));
      y = W'($urandom_range(0, 255));
      step();
      edges++;
    end
    check("done_latency", edges, W + 1);
    check("alu_req_cycles", reqs, W);
    e = exp_q.pop_front();
    check("prod_value", {16'h0, prod}, {16'h0, e});
    check("busy_at_done", {31'h0, busy}, 32'h1);
    start = 1'b0;
    step();
    check("done_one_cycle", {31'h0, done}, 32'h0);
    check("busy_clear", {31'h0, busy}, 32'h0);
    check("prod_held", {16'h0, prod}, {16'h0, e});
  endtask

  initial begin
    int last_done;
    int ndone;
    logic [2*W-1:0] e;

    vecs[0] = '{a: 8'sd3,    b: 8'sd5,    p: 16'h000F};
    vecs[1] = '{a: -8'sd7,   b: 8'sd6,    p: 16'hFFD6};
    vecs[2] = '{a: -8'sd128, b: -8'sd128, p: 16'h4000};
    vecs[3] = '{a: -8'sd128, b: 8'sd127,  p: 16'hC080};
    vecs[4] = '{a: 8'sd0,    b: -8'sd1,   p: 16'h0000};
    vecs[5] = '{a: 8'sd127,  b: 8'sd127,  p: 16'h3F01};
    vecs[6] = '{a: 8'sd5,    b: -8'sd3,   p: 16'hFFF1};
    vecs[7] = '{a: -8'sd1,   b: -8'sd1,   p: 16'h0001};
    vecs[8] = '{a: 8'sd1,    b: -8'sd128, p: 16'hFF80};
    vecs[9] = '{a: -8'sd50,  b: 8'sd0,    p: 16'h0000};

    rst = 1'b0;
    start = 1'b1;
    x = 8'd9;
    y = 8'd9;
    step();
    step();
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_prod", {16'h0, prod}, 32'h0);
    check("rst_alu_req", {31'h0, alu_req}, 32'h0);
    check("rst_state", {30'h0, fsm_state}, 32'h0);
    start = 1'b0;
    rst = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      run_mul(vecs[i].a, vecs[i].b, vecs[i].p);
    end

    // Start held high: a new product every W+3 cycles, all from the same operands.
    x = 8'sd9;
    y = -8'sd2;
    start = 1'b1;
    step();
    last_done = 0;
    ndone = 0;
    for (int i = 1; i <= 33; i++) begin
      step();
      if (done === 1'b1) begin
        ndone++;
        check("held_done_spacing", i - last_done, (ndone == 1) ? (W + 1) : (W + 3));
        check("held_prod", {16'h0, prod}, 32'h0000FFEE);
        last_done = i;
      end
    end
    check("held_done_count", ndone, 3);
    start = 1'b0;
    for (int i = 0; i < 12 && busy === 1'b1; i++) step();
    check("held_idle", {31'h0, busy}, 32'h0);

    // Reset pulse in MUL cycle 4 aborts the operation without a done pulse.
    x = -8'sd7;
    y = 8'sd6;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("abort_in_mul", {30'h0, fsm_state}, 32'h1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_prod", {16'h0, prod}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) ndone++;
      step();
    end
    check("abort_no_done", ndone, 0);
    run_mul(8'sd11, -8'sd11, 16'hFF87);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
